// File: rtl/conv_window_buf_pkg.sv
// Shared defaults and FSM encoding for the conv window line-buffer stage.
package conv_window_buf_pkg;
   localparam int DWIDTH  = 16;
   localparam int FSIZE   = 5;
   localparam int IMGSIZE = 32;
   localparam int LWIDTH  = 6;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/winbuf_line.sv
// One image line of history: single-port memory, combinational read of the
// old entry with the new entry written at the same edge (read-before-write).
module winbuf_line #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata
);
   logic [DWIDTH-1:0] mem_q [DEPTH];

   assign rdata = mem_q[addr];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end
endmodule

// File: rtl/conv_window_buf.sv
// Raster pixel stream -> FSIZE x FSIZE valid-mode sliding windows for the conv tree.
// Optional stride-2 decimation under RENKON_WINBUF_STRIDE_EN.
module conv_window_buf #(
   parameter int DWIDTH  = conv_window_buf_pkg::DWIDTH,
   parameter int FSIZE   = conv_window_buf_pkg::FSIZE,
   parameter int IMGSIZE = conv_window_buf_pkg::IMGSIZE,
   parameter int LWIDTH  = conv_window_buf_pkg::LWIDTH
) (
   input  logic                                clk,
   input  logic                                xrst,
   input  logic                                start,
   input  logic [LWIDTH-1:0]                   img_size,
`ifdef RENKON_WINBUF_STRIDE_EN
   input  logic                                stride,
`endif
   input  logic                                pixel_valid,
   input  logic [DWIDTH-1:0]                   pixel_in,
   output logic                                busy,
   output logic                                window_valid,
   output logic [FSIZE*FSIZE-1:0][DWIDTH-1:0]  window_out,
   output logic                                done
);
   import conv_window_buf_pkg::*;

   localparam int NL = FSIZE - 1;
   localparam int AW = (IMGSIZE > 1) ? $clog2(IMGSIZE) : 1;
   localparam logic [LWIDTH-1:0] SIZE_MAX = LWIDTH'(IMGSIZE);
   localparam logic [LWIDTH-1:0] FM1      = LWIDTH'(FSIZE - 1);

   state_t                             state_q, state_d;
   logic [LWIDTH-1:0]                  row_q, row_d, col_q, col_d, size_q, size_d;
   logic                               wv_q, wv_d;
   logic [FSIZE*FSIZE-1:0][DWIDTH-1:0] win_q, win_d;
   logic [NL-1:0][DWIDTH-1:0]          line_rd, line_wr;
   logic                               accept, last_col, keep;
`ifdef RENKON_WINBUF_STRIDE_EN
   logic                               stride_q, stride_d;
`endif

   assign accept   = (state_q == S_RUN) && pixel_valid && (size_q != '0);
   assign last_col = (col_q == size_q - 1'b1);

`ifdef RENKON_WINBUF_STRIDE_EN
   // FSIZE-1 is even, so offset parity from the first window equals row/col parity match.
   assign keep = !stride_q || ((row_q[0] == FM1[0]) && (col_q[0] == FM1[0]));
`else
   assign keep = 1'b1;
`endif

   // Line NL-1 holds the newest row; each accept ages every line by one.
   for (genvar k = 0; k < NL; k++) begin : g_line
      if (k == NL - 1) begin : g_new
         assign line_wr[k] = pixel_in;
      end else begin : g_old
         assign line_wr[k] = line_rd[k+1];
      end
      winbuf_line #(.DWIDTH(DWIDTH), .DEPTH(IMGSIZE), .AW(AW)) u_line (
         .clk   (clk),
         .we    (accept),
         .addr  (col_q[AW-1:0]),
         .wdata (line_wr[k]),
         .rdata (line_rd[k])
      );
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         size_q   <= '0;
         wv_q     <= 1'b0;
         win_q    <= '0;
`ifdef RENKON_WINBUF_STRIDE_EN
         stride_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         size_q   <= size_d;
         wv_q     <= wv_d;
         win_q    <= win_d;
`ifdef RENKON_WINBUF_STRIDE_EN
         stride_q <= stride_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      size_d   = size_q;
      win_d    = win_q;
      wv_d     = 1'b0;
`ifdef RENKON_WINBUF_STRIDE_EN
      stride_d = stride_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               size_d  = (img_size > SIZE_MAX) ? SIZE_MAX : img_size;
               row_d   = '0;
               col_d   = '0;
               state_d = S_RUN;
`ifdef RENKON_WINBUF_STRIDE_EN
               stride_d = stride;
`endif
            end
         end
         S_RUN: begin
            if (size_q == '0) begin
               state_d = S_DONE;
            end else if (accept) begin
               for (int r = 0; r < FSIZE; r++)
                  for (int c = 0; c < FSIZE - 1; c++)
                     win_d[r*FSIZE+c] = win_q[r*FSIZE+c+1];
               for (int r = 0; r < NL; r++)
                  win_d[r*FSIZE+FSIZE-1] = line_rd[r];
               win_d[FSIZE*FSIZE-1] = pixel_in;
               wv_d = (row_q >= FM1) && (col_q >= FM1) && keep;
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  if (row_q == size_q - 1'b1) state_d = S_DONE;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   assign window_valid = wv_q;
   assign window_out   = win_q;
endmodule

// File: tb/tb_conv_window_buf.sv
// Scoreboard bench: an FSIZE=3 instance (IMGSIZE=8) and a default FSIZE=5 instance.
// Expected windows are sliced straight out of the stimulus image array.
module tb_conv_window_buf;
   typedef logic [24:0][15:0] win_t;

   logic clk, xrst;
   logic start3, start5, pv, pv_edge;
   logic [3:0] img3;
   logic [5:0] img5;
   logic [15:0] pin;
   logic busy3, wv3, done3, busy5, wv5, done5;
   logic [8:0][15:0]  wo3;
   logic [24:0][15:0] wo5;
`ifdef RENKON_WINBUF_STRIDE_EN
   logic stride;
`endif

   int   checks = 0, errors = 0;
   int   seen[2];
   win_t q3[$], q5[$];

   conv_window_buf #(.DWIDTH(16), .FSIZE(3), .IMGSIZE(8), .LWIDTH(4)) u3 (
      .clk(clk), .xrst(xrst), .start(start3), .img_size(img3),
`ifdef RENKON_WINBUF_STRIDE_EN
      .stride(stride),
`endif
      .pixel_valid(pv), .pixel_in(pin), .busy(busy3), .window_valid(wv3),
      .window_out(wo3), .done(done3));

   conv_window_buf #(.DWIDTH(16), .FSIZE(5), .IMGSIZE(32), .LWIDTH(6)) u5 (
      .clk(clk), .xrst(xrst), .start(start5), .img_size(img5),
`ifdef RENKON_WINBUF_STRIDE_EN
      .stride(stride),
`endif
      .pixel_valid(pv), .pixel_in(pin), .busy(busy5), .window_valid(wv5),
      .window_out(wo5), .done(done5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic win_t pad3(input logic [8:0][15:0] w);
      win_t p = '0;
      for (int i = 0; i < 9; i++) p[i] = w[i];
      return p;
   endfunction

   function automatic logic busy_of(input int sel);
      return sel != 0 ? busy5 : busy3;
   endfunction
   function automatic logic done_of(input int sel);
      return sel != 0 ? done5 : done3;
   endfunction

   always @(posedge clk) pv_edge <= pv;

   task automatic mon(input int sel, input win_t got);
      win_t exp;
      chk("valid_on_accept", {399'd0, pv_edge}, 400'd1);
      seen[sel]++;
      if ((sel != 0 ? q5.size() : q3.size()) == 0) begin
         checks++;
         errors++;
         $display("FAIL extra_window(inst %0d): got %0h expected none", sel, got);
      end else begin
         exp = (sel != 0) ? q5.pop_front() : q3.pop_front();
         chk($sformatf("window(inst %0d)", sel), got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wv3) mon(0, pad3(wo3));
      if (wv5) mon(1, wo5);
   end

   // Reference: every window anchored at (r,c) with r,c >= f-1, raster order.
   task automatic model(input int sel, input int ne, input int f, input bit strd,
                        input int pix[$], output int cnt);
      win_t w;
      cnt = 0;
      for (int r = f - 1; r < ne; r++)
         for (int c = f - 1; c < ne; c++) begin
            if (strd && ((((r - f + 1) % 2) != 0) || (((c - f + 1) % 2) != 0))) continue;
            w = '0;
            for (int i = 0; i < f; i++)
               for (int j = 0; j < f; j++)
                  w[i*f+j] = 16'(pix[(r - f + 1 + i) * ne + (c - f + 1 + j)]);
            if (sel != 0) q5.push_back(w); else q3.push_back(w);
            cnt++;
         end
   endtask

   task automatic run_img(input int sel, input int n, input bit stall, input int base,
                          input int abort_at, input bit midstart, input bit strd);
      int f, mx, ne, idx, k, expn;
      int pix[$];
      f  = (sel != 0) ? 5 : 3;
      mx = (sel != 0) ? 32 : 8;
      ne = (n > mx) ? mx : n;
      for (int i = 0; i < ne * ne; i++)
         pix.push_back(base >= 0 ? base + i : int'($urandom_range(0, 65535)));
      seen[sel] = 0;
      expn = 0;
      if (abort_at < 0) model(sel, ne, f, strd, pix, expn);

      @(posedge clk); #1;
      if (sel != 0) start5 = 1'b1; else start3 = 1'b1;
      img3 = 4'(n);
      img5 = 6'(n);
`ifdef RENKON_WINBUF_STRIDE_EN
      stride = strd;
`endif
      @(posedge clk); #1;
      start3 = 1'b0;
      start5 = 1'b0;
      chk("busy_run", {399'd0, busy_of(sel)}, 400'd1);

      idx = 0;
      while (idx < ne * ne && !(abort_at >= 0 && idx >= abort_at)) begin
         pv  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         pin = pv ? 16'(pix[idx]) : 16'($urandom);
         if (midstart && idx == 5) begin
            if (sel != 0) start5 = 1'b1; else start3 = 1'b1;
            img3 = 4'd3;
            img5 = 6'd3;
         end else begin
            start3 = 1'b0;
            start5 = 1'b0;
         end
         @(posedge clk); #1;
         if (pv) idx++;
      end
      pv = 1'b0;
      start3 = 1'b0;
      start5 = 1'b0;

      if (abort_at >= 0) begin
         xrst = 1'b1;
         @(posedge clk); #1;
         xrst = 1'b0;
         chk("abort_busy", {399'd0, busy_of(sel)}, 400'd0);
         chk("abort_done", {399'd0, done_of(sel)}, 400'd0);
         chk("abort_valid", {398'd0, wv3, wv5}, 400'd0);
         chk("abort_window", (sel != 0) ? wo5 : pad3(wo3), 400'd0);
         return;
      end

      k = 0;
      while (!done_of(sel) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_pulse", {399'd0, done_of(sel)}, 400'd1);
      @(posedge clk); #1;
      chk("done_clear", {399'd0, done_of(sel)}, 400'd0);
      chk("busy_idle", {399'd0, busy_of(sel)}, 400'd0);
      @(posedge clk); #1;
      chk("win_count", 400'(seen[sel]), 400'(expn));
      chk("queue_drained", 400'((sel != 0) ? q5.size() : q3.size()), 400'd0);
   endtask

   initial begin
      xrst = 1'b1; start3 = 1'b0; start5 = 1'b0; pv = 1'b0; pin = '0;
      img3 = '0; img5 = '0;
`ifdef RENKON_WINBUF_STRIDE_EN
      stride = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 xrst = 1'b0;
      chk("rst_busy", {398'd0, busy3, busy5}, 400'd0);
      chk("rst_done", {398'd0, done3, done5}, 400'd0);
      chk("rst_valid", {398'd0, wv3, wv5}, 400'd0);
      chk("rst_win3", pad3(wo3), 400'd0);
      chk("rst_win5", wo5, 400'd0);

      run_img(0, 4, 1'b0, 0, -1, 1'b0, 1'b0);     // 4 windows, first {0,1,2,4,5,6,8,9,10}
      run_img(0, 4, 1'b1, 0, -1, 1'b0, 1'b0);     // stalled
      run_img(0, 4, 1'b0, 0, 8, 1'b0, 1'b0);      // reset after pixel 7
      run_img(0, 4, 1'b0, 100, -1, 1'b0, 1'b0);   // fresh image, no stale data
      run_img(0, 2, 1'b0, 0, -1, 1'b0, 1'b0);     // smaller than the window
      run_img(0, 0, 1'b0, 0, -1, 1'b0, 1'b0);     // empty image
      run_img(0, 6, 1'b1, -1, -1, 1'b1, 1'b0);    // start during RUN ignored
      run_img(0, 13, 1'b0, -1, -1, 1'b0, 1'b0);   // saturates to 8
      for (int t = 0; t < 3; t++)
         run_img(0, int'($urandom_range(3, 8)), 1'b1, -1, -1, 1'b0, 1'b0);
      run_img(1, 32, 1'b0, -1, -1, 1'b0, 1'b0);   // full-depth FSIZE=5
      run_img(1, 7, 1'b1, -1, -1, 1'b0, 1'b0);
`ifdef RENKON_WINBUF_STRIDE_EN
      run_img(0, 5, 1'b0, 0, -1, 1'b0, 1'b1);     // anchors at pixels 0,2,10,12
      run_img(1, 9, 1'b1, -1, -1, 1'b0, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
